// File: rtl/sub_bytes_engine.sv
// AES byte-substitution engine: LANES bytes per cycle through shared forward/inverse
// S-box lanes, 16/LANES cycles per block; valid/ready on both sides, result held under back-pressure.
module sub_bytes_engine #(
    parameter int LANES   = 4,
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_state,
    input  logic [ROUND_W-1:0] in_round,
    input  logic               in_inverse,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_state,
    output logic [ROUND_W-1:0] out_round,
    output logic               busy
);
    localparam int P  = 16 / LANES;
    localparam int CW = (P > 1) ? $clog2(P) : 1;
    localparam int GW = 8 * LANES;
    localparam logic [CW-1:0] LAST = CW'(P - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q;
    logic [127:0]       work_q;
    logic [127:0]       work_d;
    logic [ROUND_W-1:0] round_q;
    logic               mode_q;
    logic [CW-1:0]      cnt_q;
    logic [GW-1:0]      grp_in;
    logic [GW-1:0]      grp_out;
    logic               accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        acc = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] s;
        s = gf_inv(a);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    // The working register rotates left one group per pass, so the group being
    // substituted is always the top GW bits and P rotations restore byte order.
    assign grp_in = work_q[127 -: GW];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] lane_b;
        assign lane_b = grp_in[GW-1-8*l -: 8];
        assign grp_out[GW-1-8*l -: 8] = mode_q ? sbox_inv(lane_b) : sbox_fwd(lane_b);
    end

    if (LANES == 16) begin : g_full
        assign work_d = grp_out;
    end else begin : g_rot
        assign work_d = {work_q[127-GW:0], grp_out};
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign out_state = work_q;
    assign out_round = round_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= BUSY;
            work_q  <= in_state;
            round_q <= in_round;
            mode_q  <= in_inverse;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                BUSY: begin
                    work_q <= work_d;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: five instances (LANES 4,1,2,8,16) checked every cycle
// against a table-driven model, plus directed literal vectors.
module tb_sub_bytes_engine;
    localparam int NI = 5;
    localparam logic [127:0] VEC_PT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_SB = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic [NI-1:0]        in_valid;
    logic [NI-1:0]        in_inverse;
    logic [NI-1:0]        out_ready;
    logic [NI-1:0][127:0] in_state;
    logic [NI-1:0][3:0]   in_round;
    wire  [NI-1:0]        in_ready_w;
    wire  [NI-1:0]        out_valid_w;
    wire  [NI-1:0]        busy_w;
    wire  [NI-1:0][127:0] out_state_w;
    wire  [NI-1:0][3:0]   out_round_w;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    // model state, written only by the compare process
    bit           pend [NI];
    logic [127:0] exp_s [NI];
    logic [3:0]   exp_r [NI];
    int           due [NI];
    int           n_acc [NI];
    int           n_done [NI];
    int           last_hs [NI];
    int           rst_pulses = 0;

    int n_checks = 0;
    int n_pass = 0;

    function automatic int lanes_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
        sub_bytes_engine #(.LANES(L), .ROUND_W(4)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready_w[g]),
            .in_state   (in_state[g]),
            .in_round   (in_round[g]),
            .in_inverse (in_inverse[g]),
            .out_valid  (out_valid_w[g]),
            .out_ready  (out_ready[g]),
            .out_state  (out_state_w[g]),
            .out_round  (out_round_w[g]),
            .busy       (busy_w[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from the generator-3 log walk; inverse table by inverting the permutation.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            fwd_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end
        fwd_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
    endtask

    function automatic logic [127:0] sub_block(input logic [127:0] s, input logic m);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = s[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = m ? inv_t[b] : fwd_t[b];
        end
        return r;
    endfunction

    // compare process: one model step per cycle for every instance
    initial begin : cmp
        logic ov;
        logic rdy;
        int   rst_seen;
        rst_seen = 0;
        for (int g = 0; g < NI; g++) begin
            pend[g] = 0; n_acc[g] = 0; n_done[g] = 0; last_hs[g] = 0; due[g] = 0;
            exp_s[g] = '0; exp_r[g] = '0;
        end
        forever begin
            @(negedge clk);
            if (rst_pulses != rst_seen) begin
                rst_seen = rst_pulses;
                for (int g = 0; g < NI; g++) pend[g] = 0;
            end
            if (!rst) begin
                for (int g = 0; g < NI; g++) begin
                    ov  = pend[g] && (cyc >= due[g]);
                    rdy = !pend[g] || (ov && out_ready[g]);
                    check("out_valid", g, out_valid_w[g], ov);
                    check("busy", g, busy_w[g], pend[g] && (cyc < due[g]));
                    check("in_ready", g, in_ready_w[g], rdy);
                    if (ov) begin
                        check("out_state", g, out_state_w[g], exp_s[g]);
                        check("out_round", g, out_round_w[g], exp_r[g]);
                    end
                    if (ov && out_ready[g]) begin
                        pend[g] = 0;
                        n_done[g]++;
                        last_hs[g] = cyc + 1;
                    end
                    if (in_valid[g] && rdy) begin
                        pend[g]  = 1;
                        exp_s[g] = sub_block(in_state[g], in_inverse[g]);
                        exp_r[g] = in_round[g];
                        due[g]   = cyc + 1 + 16 / lanes_of(g);
                        n_acc[g]++;
                    end
                end
            end
        end
    end

    task automatic wait_ready(input int g, input string nm);
        bit ok;
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (in_ready_w[g]) ok = 1;
        end
        check(nm, g, ok, 1);
    endtask

    task automatic run_block(input int g, input logic [127:0] s, input logic [3:0] r, input logic m,
                             output logic [127:0] res, output int lat);
        int t_acc;
        bit ok;
        @(posedge clk); #1;
        in_valid[g] = 1; in_state[g] = s; in_round[g] = r; in_inverse[g] = m;
        wait_ready(g, "accept_wait");
        t_acc = cyc + 1;
        @(posedge clk); #1;
        in_valid[g] = 0;
        ok = 0; lat = -1; res = '0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (out_valid_w[g]) begin
                ok = 1; lat = cyc - t_acc; res = out_state_w[g];
            end
        end
        check("result_wait", g, ok, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : drive
        logic [127:0] res;
        int lat;
        int a0;
        int d0;
        int first;
        bit ok;
        in_valid = '0; in_inverse = '0; out_ready = '1;
        for (int g = 0; g < NI; g++) begin in_state[g] = '0; in_round[g] = '0; end
        build_tables();

        // the model tables against FIPS-197 literals
        check("tbl_fwd53", 0, fwd_t[8'h53], 8'hed);
        check("tbl_fwd00", 0, fwd_t[8'h00], 8'h63);
        check("tbl_inv63", 0, inv_t[8'h63], 8'h00);
        check("tbl_invED", 0, inv_t[8'hed], 8'h53);
        check("model_fwd_vec", 0, sub_block(VEC_PT, 1'b0), VEC_SB);
        check("model_inv_vec", 0, sub_block(VEC_SB, 1'b1), VEC_PT);

        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check("rst_in_ready", g, in_ready_w[g], 1);
            check("rst_out_valid", g, out_valid_w[g], 0);
            check("rst_busy", g, busy_w[g], 0);
            check("rst_out_state", g, out_state_w[g], 0);
            check("rst_out_round", g, out_round_w[g], 0);
        end

        // forward and inverse vectors on LANES=4
        run_block(0, VEC_PT, 4'd3, 1'b0, res, lat);
        check("fwd_state", 0, res, VEC_SB);
        check("fwd_round", 0, out_round_w[0], 3);
        check("fwd_latency", 0, lat, 4);
        run_block(0, VEC_SB, 4'd7, 1'b1, res, lat);
        check("inv_state", 0, res, VEC_PT);
        run_block(0, 128'h63ed6363636363636363636363636363, 4'd1, 1'b1, res, lat);
        check("inv_bytes", 0, res, 128'h00530000000000000000000000000000);

        // back-pressure: result held, later offer ignored, then same-edge handoff
        @(posedge clk); #1;
        a0 = n_acc[0];
        out_ready[0] = 0;
        in_valid[0] = 1; in_state[0] = VEC_PT; in_round[0] = 4'd5; in_inverse[0] = 0;
        wait_ready(0, "bp_accept_wait");
        @(posedge clk); #1;
        in_state[0] = VEC_SB; in_round[0] = 4'd9;
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (out_valid_w[0]) ok = 1;
        end
        check("bp_result_wait", 0, ok, 1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_inverse[0] = ~in_inverse[0];
            @(negedge clk);
            check("bp_hold_state", k, out_state_w[0], VEC_SB);
            check("bp_hold_round", k, out_round_w[0], 5);
            check("bp_in_ready", k, in_ready_w[0], 0);
        end
        @(posedge clk); #1;
        in_inverse[0] = 1; out_ready[0] = 1;
        @(negedge clk);
        check("bp_handoff_ready", 0, in_ready_w[0], 1);
        @(posedge clk); #1;
        in_valid[0] = 0;
        check("bp_accept_count", 0, n_acc[0] - a0, 2);
        @(negedge clk);
        check("bp_after_valid", 0, out_valid_w[0], 0);
        check("bp_after_busy", 0, busy_w[0], 1);
        ok = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (out_valid_w[0]) ok = 1;
        end
        check("bp_second_wait", 0, ok, 1);
        check("bp_second_state", 0, out_state_w[0], VEC_PT);
        check("bp_second_round", 0, out_round_w[0], 9);

        // lane-count sweep
        for (int g = 1; g < NI; g++) begin
            run_block(g, VEC_PT, 4'd3, 1'b0, res, lat);
            check("sweep_state", g, res, VEC_SB);
            check("sweep_latency", g, lat, 16 / lanes_of(g));
        end

        // asynchronous reset after two passes
        repeat (2) @(posedge clk);
        #1;
        in_valid[0] = 1; in_state[0] = VEC_PT; in_round[0] = 4'd6; in_inverse[0] = 0;
        wait_ready(0, "rst_accept_wait");
        @(posedge clk); #1;
        in_valid[0] = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("arst_out_valid", 0, out_valid_w[0], 0);
        check("arst_out_state", 0, out_state_w[0], 0);
        check("arst_out_round", 0, out_round_w[0], 0);
        check("arst_in_ready", 0, in_ready_w[0], 1);
        check("arst_busy", 0, busy_w[0], 0);
        #1 rst = 0;
        rst_pulses++;
        repeat (6) @(posedge clk);
        run_block(0, VEC_PT, 4'd2, 1'b0, res, lat);
        check("post_rst_state", 0, res, VEC_SB);
        check("post_rst_latency", 0, lat, 4);

        // back-to-back stream, alternating mode
        @(posedge clk); #1;
        a0 = n_acc[0];
        d0 = n_done[0];
        first = 0;
        for (int i = 0; i < 8; i++) begin
            in_state[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_round[0] = 4'(i);
            in_inverse[0] = i[0];
            in_valid[0] = 1;
            wait_ready(0, "stream_accept_wait");
            if (i == 0) first = cyc + 1;
            @(posedge clk); #1;
        end
        in_valid[0] = 0;
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clk); #1;
            if (n_done[0] == d0 + 8) ok = 1;
        end
        check("stream_done_wait", 0, ok, 1);
        check("stream_accepts", 0, n_acc[0] - a0, 8);
        check("stream_results", 0, n_done[0] - d0, 8);
        // each block spends P busy cycles plus one DONE cycle that overlaps the next acceptance
        check("stream_span", 0, last_hs[0] - first, 8 * (4 + 1));

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
